sad_scan_counter: RTL
=====================

# sad_scan_counter

Parametrised two-level scan counter for the SAD datapath. It generates the pixel index within a block and the candidate (search-position) index for one full SAD search, under a start/busy/done handshake with per-cycle stall. It replaces the free-running single-level index counter in front of the pixel memories and the SAD accumulator. The pixel index drives memory addressing; `last_pix` drives accumulator compare/clear.

## Interface
- `PIX_W`, default 9: width of `pix`.
- `N_PIX`, default 256: pixels per block. Legal range is 2 to 2^PIX_W.
- `CAND_W`, default 6: width of `cand`.
- `N_CAND`, default 64: candidates per search. Legal range is 1 to 2^CAND_W.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a search. Sampled only in IDLE.
- `en`  in  1  advance enable. Low stalls the counters and holds outputs.
- `abort`  in  1  cancel the search. Present only with `SAD_SCAN_ABORT_EN`.
- `pix`  out  PIX_W  current pixel index.
- `cand`  out  CAND_W  current candidate index.
- `valid`  out  1  `pix`/`cand` are a live address; high throughout RUN.
- `last_pix`  out  1  `valid & (pix == N_PIX-1)`.
- `last`  out  1  `last_pix & (cand == N_CAND-1)`.
- `busy`  out  1  state is RUN or DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, RUN and DONE, held in a registered state.
- `valid`, `busy` and `done` decode directly from state. `last_pix` and `last` are combinational from the registers.
- Reset values: state IDLE, `pix`=0, `cand`=0. All outputs are 0.
- **IDLE**
  - `start`=1: go to RUN with `pix`=0 and `cand`=0.
  - Otherwise: hold.
- **RUN**
  - `en`=0: hold `pix`, `cand` and state.
  - `en`=1 and `pix`<N_PIX-1: `pix`+1.
  - `en`=1, `pix`=N_PIX-1 and `cand`<N_CAND-1: `pix`=0, `cand`+1.
  - `en`=1 on `last`: `pix`=0, `cand`=0, go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `start` is ignored in RUN and DONE. It is not queued.
- Arithmetic is unsigned. Counters never exceed N_PIX-1 or N_CAND-1. Wrap is by explicit compare, not natural overflow, so non-power-of-two N_PIX/N_CAND work.
- When N_CAND=1, `last_pix` and `last` coincide.
- Priority: `rst` > `abort` > `en` > `start`.
- `rst` in any state, including mid-RUN, returns to IDLE with counters at 0 on the next edge. No `done` is issued.

## Timing
- `start` high at edge t: `valid`=1, `pix`=0, `cand`=0 after edge t.
- With `en` held high, the search lasts N_PIX·N_CAND cycles of `valid`.
- `done` is high in the cycle after the last `valid` cycle.
- `busy` falls one cycle after `done`.
- Earliest restart is `start` in the cycle after `done`.
- Back-to-back searches therefore have a 2-cycle gap (DONE plus IDLE).
- Each low-`en` cycle during RUN extends the search by exactly one cycle.

## Configuration
- `SAD_SCAN_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in RUN forces IDLE and clears `pix`/`cand` on the next edge, regardless of `en`.
  - No `done` pulse is issued.
  - `abort` in IDLE or DONE has no effect; DONE still pulses.
- `SAD_SCAN_ABORT_EN` undefined: no `abort` port, and a search always runs to completion or `rst`.

## Test plan
Bench parameters: N_PIX=4, N_CAND=3, PIX_W=2, CAND_W=2.
- **Reset:** `rst`=1 for 2 cycles with `start`=1 -> all outputs stay 0 and state is IDLE.
- **Full scan:** `start` pulse, `en`=1 -> 12 `valid` cycles with (`cand`,`pix`) sequence (0,0),(0,1)…(2,3).
  - `last_pix` is high on `pix`=3.
  - `last` is high only at (2,3).
  - `done` is high 1 cycle later, then `busy`=0.
- **Stall:** `en`=0 for 3 cycles at (1,2) -> outputs hold (1,2). `done` arrives 3 cycles later than in the full-scan case.
- **Start while busy:** `start`=1 in RUN and in DONE -> ignored. No restart and no second `done`.
- **Mid-run reset:** `rst` at (1,1) -> IDLE with 0/0 next cycle and no `done`. A new `start` runs the full 12 cycles.
- **Abort (`SAD_SCAN_ABORT_EN`):** `abort`=1 together with `en`=1 at (0,3) -> IDLE next cycle, counters 0, no `done` pulse.

Source files
------------

// File: rtl/sad_scan_counter_if.sv
// Handshake and index bus between a SAD search controller and sad_scan_counter.
// The abort wire exists only when SAD_SCAN_ABORT_EN is defined.
interface sad_scan_counter_if #(
    parameter int unsigned PIX_W  = 9,
    parameter int unsigned CAND_W = 6
);
    logic              start;
    logic              en;
`ifdef SAD_SCAN_ABORT_EN
    logic              abort;
`endif
    logic [PIX_W-1:0]  pix;
    logic [CAND_W-1:0] cand;
    logic              valid;
    logic              last_pix;
    logic              last;
    logic              busy;
    logic              done;

`ifdef SAD_SCAN_ABORT_EN
    modport master (
        output start, en, abort,
        input  pix, cand, valid, last_pix, last, busy, done
    );
    modport slave (
        input  start, en, abort,
        output pix, cand, valid, last_pix, last, busy, done
    );
`else
    modport master (
        output start, en,
        input  pix, cand, valid, last_pix, last, busy, done
    );
    modport slave (
        input  start, en,
        output pix, cand, valid, last_pix, last, busy, done
    );
`endif
endinterface

// File: rtl/sad_scan_counter.sv
// Two-level scan counter for the SAD datapath: pixel index within a block (inner)
// and candidate index (outer), run under a start/busy/done handshake with stall.
// Define SAD_SCAN_ABORT_EN to add the abort input that cancels a running search.
module sad_scan_counter #(
    parameter int unsigned PIX_W  = 9,
    parameter int unsigned N_PIX  = 256,
    parameter int unsigned CAND_W = 6,
    parameter int unsigned N_CAND = 64
) (
    input logic               clk,
    input logic               rst,
    sad_scan_counter_if.slave bus
);
    // Terminal counts; wrap is by compare so non-power-of-two sizes work.
    localparam logic [PIX_W-1:0]  PixMax  = PIX_W'(N_PIX - 1);
    localparam logic [CAND_W-1:0] CandMax = CAND_W'(N_CAND - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state;
    logic [PIX_W-1:0]  pix_q;
    logic [CAND_W-1:0] cand_q;

    // State and both counters; rst beats abort beats en beats start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            pix_q  <= '0;
            cand_q <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        state  <= StRun;
                        pix_q  <= '0;
                        cand_q <= '0;
                    end
                end
                StRun: begin
`ifdef SAD_SCAN_ABORT_EN
                    if (bus.abort) begin
                        state  <= StIdle;
                        pix_q  <= '0;
                        cand_q <= '0;
                    end else
`endif
                    if (bus.en) begin
                        if (pix_q != PixMax) begin
                            pix_q <= pix_q + 1'b1;
                        end else if (cand_q != CandMax) begin
                            pix_q  <= '0;
                            cand_q <= cand_q + 1'b1;
                        end else begin
                            // Final address consumed: one DONE cycle follows.
                            pix_q  <= '0;
                            cand_q <= '0;
                            state  <= StDone;
                        end
                    end
                end
                StDone: state <= StIdle;
                default: begin
                    state  <= StIdle;
                    pix_q  <= '0;
                    cand_q <= '0;
                end
            endcase
        end
    end

    // Outputs decode straight from the registers; no extra pipeline stage.
    always_comb begin
        bus.pix      = pix_q;
        bus.cand     = cand_q;
        bus.valid    = (state == StRun);
        bus.busy     = (state != StIdle);
        bus.done     = (state == StDone);
        bus.last_pix = bus.valid && (pix_q == PixMax);
        bus.last     = bus.last_pix && (cand_q == CandMax);
    end
endmodule
